// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
// Holds the controller state encoding and the default operand width.
package serial_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sadd_state_t;

  localparam int DEFAULT_NUM_BITS = 8;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester and the serial adder controller.
// The requester drives the start and operands; the controller returns status and result.
interface serial_adder_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int NUM_BITS = DEFAULT_NUM_BITS
);

  logic                start;
  logic [NUM_BITS-1:0] a;
  logic [NUM_BITS-1:0] b;
  logic                carry_in;
  logic                busy;
  logic                done;
  logic [NUM_BITS-1:0] sum;
  logic                carry_out;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, carry_out
  );

endinterface

// File: rtl/serial_adder_ctrl_adder_1bit.sv
// One-bit full adder slice.
// Latency: purely combinational.
// Backpressure: none; the result follows the inputs.
module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  logic half;

  assign half      = a ^ b;
  assign sum       = half ^ carry_in;
  assign carry_out = (a & b) | (carry_in & half);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial NUM_BITS adder: one bit pair per clock, LSB first, through a single adder_1bit.
// Latency: done pulses in the cycle after edge k+NUM_BITS for a start accepted at edge k.
// Backpressure: start is ignored while busy; it is taken in IDLE or DONE, allowing back-to-back runs.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 1);

  sadd_state_t         state, state_nxt;
  logic [NUM_BITS-1:0] a_sr, b_sr, sum_sr, sum_q;
  logic                carry_r, carry_out_q;
  logic [CNT_W-1:0]    cnt;
  logic                load, last_bit;
  logic                add_sum, add_carry;

  assign load     = bus.start && (state == IDLE || state == DONE);
  assign last_bit = (state == RUN) && (cnt == CNT_LAST);

  adder_1bit u_adder (
    .a         (a_sr[0]),
    .b         (b_sr[0]),
    .carry_in  (carry_r),
    .sum       (add_sum),
    .carry_out (add_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_sr        <= '0;
      b_sr        <= '0;
      sum_sr      <= '0;
      sum_q       <= '0;
      carry_r     <= 1'b0;
      carry_out_q <= 1'b0;
      cnt         <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        a_sr    <= bus.a;
        b_sr    <= bus.b;
        carry_r <= bus.carry_in;
        cnt     <= '0;
      end else if (state == RUN) begin
        a_sr    <= a_sr >> 1;
        b_sr    <= b_sr >> 1;
        sum_sr  <= {add_sum, sum_sr[NUM_BITS-1:1]};
        carry_r <= add_carry;
        // Counter parks on the last index so it never wraps inside an operation.
        if (!last_bit) cnt <= cnt + CNT_W'(1);
        if (last_bit) begin
          sum_q       <= {add_sum, sum_sr[NUM_BITS-1:1]};
          carry_out_q <= add_carry;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state == RUN);
    bus.done      = (state == DONE);
    bus.sum       = sum_q;
    bus.carry_out = carry_out_q;
  end

  always @(posedge clk) begin
    if (!rst && load) begin
      assert (!$isunknown({bus.a, bus.b, bus.carry_in}))
        else $error("serial_adder_ctrl: X/Z on operands at accepted start");
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl with hand-computed sums and latencies.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  serial_adder_ctrl_if #(.NUM_BITS(8)) bus ();

  serial_adder_ctrl #(.NUM_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Advance until done is seen or the budget runs out; counts busy cycles on the way.
  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      if (bus.busy === 1'b1) nbusy++;
      tick();
      n++;
    end
  endtask

  task automatic check_result(input string name, input logic [7:0] es, input logic eco);
    checks++;
    if (bus.sum !== es) begin
      errors++;
      $display("FAIL %s sum got %h want %h", name, bus.sum, es);
    end
    checks++;
    if (bus.carry_out !== eco) begin
      errors++;
      $display("FAIL %s carry_out got %b want %b", name, bus.carry_out, eco);
    end
  endtask

  task automatic do_add(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [7:0] es, input logic eco);
    int n, nbusy;
    bus.a = a; bus.b = b; bus.carry_in = ci; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(n, nbusy);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL %s latency got %0d want 8", name, n);
    end
    check_result(name, es, eco);
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.carry_in = 1'b0;
    tick(); tick();
    checks++;
    if ({bus.busy, bus.done, bus.carry_out} !== 3'b000 || bus.sum !== 8'h00) begin
      errors++;
      $display("FAIL reset busy/done/co got %b%b%b sum %h want 000 sum 00",
               bus.busy, bus.done, bus.carry_out, bus.sum);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    int n, nbusy;
    bus.a = 8'h0F; bus.b = 8'h01; bus.carry_in = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(n, nbusy);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL basic latency got %0d want 8", n); end
    checks++;
    if (nbusy !== 8) begin errors++; $display("FAIL basic busy_cycles got %0d want 8", nbusy); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic busy_in_done got %b want 0", bus.busy); end
    check_result("basic", 8'h10, 1'b0);
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.sum !== 8'h10) begin
      errors++;
      $display("FAIL basic hold done %b sum %h want done 0 sum 10", bus.done, bus.sum);
    end
  endtask

  task automatic test_carry;
    do_add("ff_plus_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    tick();
    do_add("ff_ff_ci", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    tick();
    do_add("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
  endtask

  task automatic test_start_ignored;
    int n, nbusy;
    bus.a = 8'h12; bus.b = 8'h34; bus.carry_in = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    bus.a = 8'hAA; bus.b = 8'h55; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(n, nbusy);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL ignore remaining_latency got %0d want 5", n); end
    check_result("ignore", 8'h46, 1'b0);
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL ignore after busy %b done %b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_mid_run;
    int ndone;
    bus.a = 8'h80; bus.b = 8'h80; bus.carry_in = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.carry_out} !== 3'b000 || bus.sum !== 8'h00) begin
      errors++;
      $display("FAIL midreset busy/done/co got %b%b%b sum %h want 000 sum 00",
               bus.busy, bus.done, bus.carry_out, bus.sum);
    end
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done === 1'b1) ndone++;
      tick();
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL midreset done_pulses got %0d want 0", ndone); end
    do_add("after_reset", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back;
    int n, nbusy;
    bus.a = 8'h01; bus.b = 8'h02; bus.carry_in = 1'b0; bus.start = 1'b1;
    tick();
    wait_done(n, nbusy);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL b2b first_latency got %0d want 8", n); end
    check_result("b2b_first", 8'h03, 1'b0);
    bus.a = 8'h10; bus.b = 8'h20;
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b restart busy %b done %b want 1 0", bus.busy, bus.done);
    end
    bus.start = 1'b0;
    wait_done(n, nbusy);
    checks++;
    if (n + 1 !== 9) begin errors++; $display("FAIL b2b done_spacing got %0d want 9", n + 1); end
    check_result("b2b_second", 8'h30, 1'b0);
    tick();
  endtask

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.carry_in = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder controller that sits directly upstream of the 1-bit full-adder cell.
- Latches two N-bit operands, feeds one bit pair per clock (LSB first) plus a registered carry into a single adder_1bit instance, and shifts the produced sum bits into a result register.
- Reports completion with a one-cycle done pulse and a final carry-out.
- Serves as the area-minimal alternative to the ripple-carry adder in the lab datapath.

Parameters:
NUM_BITS, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request to begin an addition; sampled only in IDLE or DONE
a  input  NUM_BITS  operand A, captured on accepted start
b  input  NUM_BITS  operand B, captured on accepted start
carry_in  input  1  initial carry, captured on accepted start
busy  output  1  high while the operation is in progress (RUN state)
done  output  1  one-cycle pulse when sum/carry_out are final
sum  output  NUM_BITS  result register; held stable from done until the next accepted start
carry_out  output  1  final carry of the addition; held with sum

Behaviour:
- Reset: synchronous and active-high; when rst=1 at a clock edge, go to IDLE. Reset clears operand shift registers, the sum register, the carry register and the bit counter. The outputs reset as follows: busy=0, done=0, sum=0, carry_out=0. Reset takes priority over every other event, including a reset mid-RUN, which discards the operation without asserting done.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> load a_sr<=a, b_sr<=b, carry_r<=carry_in, cnt<=0; next RUN.
  - sum and carry_out keep their previous values.
- RUN:
  - busy=1.
  - adder_1bit inputs are a_sr[0], b_sr[0] and carry_r.
  - Each edge: a_sr and b_sr shift right by 1; sum_sr<= {adder sum, sum_sr[NUM_BITS-1:1]}; carry_r<=adder carry_out; cnt<=cnt+1.
  - When cnt==NUM_BITS-1 on an edge, next state is DONE and the sum/carry_out outputs update from the final shifted values on that edge.
  - start is ignored in RUN; the operands are not disturbed.
- DONE:
  - done=1 for exactly this one cycle; busy=0; sum and carry_out are valid.
  - start=1 in DONE is accepted: operands load as in IDLE and next state is RUN (back-to-back operation, no idle bubble). Otherwise next state is IDLE.
- Latency: start accepted at edge k -> done high in the cycle after edge k+NUM_BITS. For NUM_BITS=8, done is observed 9 cycles after start is sampled.
- Throughput: one addition per NUM_BITS+1 cycles with continuous start.
- Width rules:
  - cnt width is $clog2(NUM_BITS); cnt must never wrap within an operation.
  - sum is modulo 2^NUM_BITS; the overflow bit appears only on carry_out.
- Input check: when start is accepted, assert that a, b and carry_in contain no X/Z values; raise $error if they do.
- The sum and carry_out outputs are registered. There is no combinational path from the inputs to any output.

Decomposition:
- Shared package serial_add_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sadd_state_t;
  - localparam DEFAULT_NUM_BITS = 8.
- Sub-module: one instance of adder_1bit for the bit-slice arithmetic.
- Controller, shift registers and counter stay in serial_adder_ctrl.

Test Plan:
- Reset, then a=8'h0F, b=8'h01, carry_in=0, start pulse -> busy high for 8 cycles; done pulses 9 cycles after start; sum=8'h10, carry_out=0.
- a=8'hFF, b=8'h01, carry_in=0 -> sum=8'h00, carry_out=1.
- a=8'hFF, b=8'hFF, carry_in=1 -> sum=8'hFF, carry_out=1. Then a=8'h00, b=8'h00, carry_in=0 -> sum=8'h00, carry_out=0.
- Start 8'h12+8'h34, then pulse start with a=8'hAA, b=8'h55 at cycle 3 of RUN -> second request ignored; result sum=8'h46, carry_out=0.
- Start 8'h80+8'h80; assert rst at cycle 4 of RUN -> next cycle busy=0, sum=0, carry_out=0; no done pulse; a new start then completes normally.
- Back-to-back: hold start=1 with 8'h01+8'h02, then 8'h10+8'h20 applied in the DONE cycle -> done pulses twice, 9 cycles apart; sum reads 8'h03, then 8'h30.
